// File: rtl/sky1_prog_loader.sv
// sky1_prog_loader: framed byte-stream loader (SYNC, LEN, payload, XOR CHK) that
// writes the payload into the core's instruction memory and gates core execution.
module sky1_prog_loader #(
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              run_en_o,
    output logic              load_done_o,
    output logic              csum_err_o,
    output logic              len_err_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LEN, DATA, CHK} state_t;

    state_t            state_q;
    logic [LW-1:0]     len_q, cnt_q, cnt_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic              in_ready_q, mem_we_q, run_en_q, load_done_q, csum_err_q, len_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              xfer, len_ok;

    assign xfer   = in_valid_i & in_ready_q;
    assign cnt_d  = cnt_q + 1'b1;
    assign chk_d  = chk_q ^ in_data_i;
    // LEN counts bytes, so 2**ADDR_W itself is legal and needs the extra bit in len_q
    assign len_ok = (in_data_i != '0) && (32'(in_data_i) <= 32'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            run_en_q    <= 1'b0;
            load_done_q <= 1'b0;
            csum_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            if (xfer) begin
                case (state_q)
                    IDLE: if (in_data_i == SYNC_BYTE) begin
                        state_q    <= LEN;
                        run_en_q   <= 1'b0;
                        csum_err_q <= 1'b0;
                        len_err_q  <= 1'b0;
                        chk_q      <= '0;
                    end
                    LEN: if (len_ok) begin
                        len_q   <= LW'(in_data_i);
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        len_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                    DATA: begin
                        chk_q       <= chk_d;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR + cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= in_data_i;
                        cnt_q       <= cnt_d;
                        state_q     <= (cnt_d == len_q) ? CHK : DATA;
                    end
                    default: begin
                        run_en_q    <= (in_data_i == chk_q);
                        load_done_q <= (in_data_i == chk_q);
                        csum_err_q  <= (in_data_i != chk_q);
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign run_en_o    = run_en_q;
    assign load_done_o = load_done_q;
    assign csum_err_o  = csum_err_q;
    assign len_err_o   = len_err_q;
endmodule

// File: tb/tb_sky1_prog_loader.sv
// tb_sky1_prog_loader: scoreboard bench; two loaders (base 0 and base 7F) share
// the stream, sel picks which one receives in_valid and is monitored.
module tb_sky1_prog_loader;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sel = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       rdy0, rdy1, we0, we1, run0, run1, ld0, ld1, ce0, ce1, le0, le1;
    logic [6:0] addr0, addr1;
    logic [7:0] wd0, wd1;
    logic       s_rdy, s_we, s_run, s_ld, s_ce, s_le;
    logic [6:0] s_addr;
    logic [7:0] s_wd;

    typedef struct {logic [6:0] a; logic [7:0] d; int c;} wr_t;
    wr_t q[$];
    wr_t e_m;
    int  tests = 0, fails = 0, cyc = 0, ld_cnt = 0, acc = 0;
    logic [7:0] x;
    logic [7:0] pay;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sky1_prog_loader dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid & ~sel), .in_data_i(in_data),
        .in_ready_o(rdy0), .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0),
        .run_en_o(run0), .load_done_o(ld0), .csum_err_o(ce0), .len_err_o(le0)
    );
    sky1_prog_loader #(.BASE_ADDR(7'h7F)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid & sel), .in_data_i(in_data),
        .in_ready_o(rdy1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
        .run_en_o(run1), .load_done_o(ld1), .csum_err_o(ce1), .len_err_o(le1)
    );

    assign s_rdy  = sel ? rdy1  : rdy0;
    assign s_we   = sel ? we1   : we0;
    assign s_addr = sel ? addr1 : addr0;
    assign s_wd   = sel ? wd1   : wd0;
    assign s_run  = sel ? run1  : run0;
    assign s_ld   = sel ? ld1   : ld0;
    assign s_ce   = sel ? ce1   : ce0;
    assign s_le   = sel ? le1   : le0;

    // Monitor: every write strobe must match the oldest expected write, in the cycle after acceptance
    always @(negedge clk) begin
        if (s_we) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%h data=%h", s_addr, s_wd);
            end else begin
                e_m = q.pop_front();
                if (s_addr !== e_m.a || s_wd !== e_m.d || cyc != e_m.c) begin
                    fails++;
                    $display("FAIL write got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                             s_addr, s_wd, cyc, e_m.a, e_m.d, e_m.c);
                end
            end
        end
        if (sel ? we0 : we1) begin
            tests++;
            fails++;
            $display("FAIL idle_instance_write got we=1 exp we=0");
        end
        if (s_ld) ld_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!s_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!s_rdy) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout got ready=0 exp ready=1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic sd(input logic [7:0] b, input logic [6:0] a);
        send(b);
        q.push_back('{a, b, acc});
    endtask

    task automatic flags(input string nm, input logic run, input logic ce, input logic le, input int ld);
        repeat (3) @(negedge clk);
        chk({nm, "_run_en"}, 32'(s_run), 32'(run));
        chk({nm, "_csum_err"}, 32'(s_ce), 32'(ce));
        chk({nm, "_len_err"}, 32'(s_le), 32'(le));
        chk({nm, "_load_done_cnt"}, 32'(ld_cnt), 32'(ld));
        chk({nm, "_writes_pending"}, 32'(q.size()), 32'd0);
        ld_cnt = 0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ready"}, 32'(rdy0), 32'd0);
        chk({nm, "_out"}, {8'(we0), 8'(addr0), wd0, 4'(run0), 4'(ld0)}, 32'd0);
        chk({nm, "_err"}, {ce0, le0}, 2'b00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ld_cnt = 0;

        send(8'hA5); send(8'h03); sd(8'h01, 7'h00); sd(8'h05, 7'h01); sd(8'h02, 7'h02); send(8'h06);
        flags("good", 1'b1, 1'b0, 1'b0, 1);

        send(8'hA5); send(8'h03); sd(8'h01, 7'h00); sd(8'h05, 7'h01); sd(8'h02, 7'h02); send(8'h07);
        flags("badchk", 1'b0, 1'b1, 1'b0, 0);

        send(8'h00); send(8'hFF); send(8'h13);
        send(8'hA5); send(8'h01); sd(8'h0A, 7'h00); send(8'h0A);
        flags("junk", 1'b1, 1'b0, 1'b0, 1);

        send(8'hA5); send(8'h00);
        flags("len00", 1'b0, 1'b0, 1'b1, 0);
        send(8'hA5); send(8'h81);
        flags("len81", 1'b0, 1'b0, 1'b1, 0);
        send(8'hA5); send(8'h01); sd(8'h33, 7'h00); send(8'h33);
        flags("lenclr", 1'b1, 1'b0, 1'b0, 1);

        // Full-depth frame on the base-7F loader, one payload byte equal to SYNC
        sel = 1'b1;
        x = 8'h00;
        send(8'hA5); send(8'h80);
        for (int i = 0; i < 128; i++) begin
            pay = (i == 5) ? 8'hA5 : 8'(i * 7 + 3);
            x = x ^ pay;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sd(pay, 7'(8'h7F + i));
        end
        send(x);
        flags("wrap", 1'b1, 1'b0, 1'b0, 1);
        sel = 1'b0;

        send(8'hA5); send(8'h03); sd(8'h11, 7'h00); sd(8'h22, 7'h01);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk_reset("midreset");
        chk("midreset_pending", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ld_cnt = 0;
        send(8'hA5); send(8'h02); sd(8'h10, 7'h00); sd(8'h20, 7'h01); send(8'h30);
        flags("afterrst", 1'b1, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
